// File: rtl/axi4_pkg.sv
// Shared AXI4 definitions for the burst master: response codes, FSM state
// encoding and the read-response accumulation rule.
package axi4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW_REQ,
    ST_W_DATA,
    ST_B_WAIT,
    ST_AR_REQ,
    ST_R_DATA
  } state_t;

  // Worst-of two responses; numeric order makes SLVERR/DECERR dominate OKAY.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi4_burst_master_if.sv
// Five-channel AXI4 bus between the burst master and a memory-mapped slave.
interface axi4_burst_master_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16
);

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic [7:0]            AWLEN;
  logic [2:0]            AWSIZE;
  logic                  AWVALID;
  logic                  AWREADY;

  logic [DATA_WIDTH-1:0] WDATA;
  logic                  WVALID;
  logic                  WLAST;
  logic                  WREADY;

  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;

  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic                  ARVALID;
  logic                  ARREADY;

  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RLAST;
  logic                  RREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWVALID, input AWREADY,
    output WDATA, WVALID, WLAST, input WREADY,
    input  BRESP, BVALID, output BREADY,
    output ARADDR, ARLEN, ARSIZE, ARVALID, input ARREADY,
    input  RDATA, RRESP, RVALID, RLAST, output RREADY
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWVALID, output AWREADY,
    input  WDATA, WVALID, WLAST, output WREADY,
    output BRESP, BVALID, input BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, RLAST, input RREADY
  );

endinterface

// File: rtl/axi4_burst_master.sv
// Command-driven AXI4 master: one {write|read, addr, len} command becomes a
// single INCR burst; write beats come from a stream, read beats go to one.
module axi4_burst_master
  import axi4_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter logic [2:0]  BEAT_SIZE  = 3'($clog2(DATA_WIDTH / 8))
) (
  input  logic                  ACLK,
  input  logic                  ARESETn,

  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [7:0]            cmd_len,

  input  logic [DATA_WIDTH-1:0] wd_data,
  input  logic                  wd_valid,
  output logic                  wd_ready,

  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  rd_last,
  input  logic                  rd_ready,

  output logic                  done,
  output logic [1:0]            done_resp,

  axi4_burst_master_if.master   m_axi
);

  state_t                r_state;
  logic                  r_cmd_ready;
  logic                  r_awvalid;
  logic                  r_arvalid;
  logic                  r_bready;
  logic                  r_done;
  logic [1:0]            r_done_resp;
  logic [1:0]            r_resp_acc;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_cnt;

  logic                  w_in_w;
  logic                  w_in_r;
  logic                  w_w_hs;
  logic                  w_r_hs;
  logic                  w_cnt_at_len;
  logic [1:0]            w_resp_next;

  assign w_in_w       = (r_state == ST_W_DATA);
  assign w_in_r       = (r_state == ST_R_DATA);
  assign w_cnt_at_len = (r_cnt == r_len);
  assign w_w_hs       = w_in_w & wd_valid & m_axi.WREADY;
  assign w_r_hs       = w_in_r & m_axi.RVALID & rd_ready;
  assign w_resp_next  = resp_max(r_resp_acc, m_axi.RRESP);

  // Data channels are pure pass-through, gated by state so nothing leaks
  // outside the burst's own data phase.
  assign m_axi.WVALID = w_in_w & wd_valid;
  assign m_axi.WDATA  = w_in_w ? wd_data : '0;
  assign m_axi.WLAST  = w_in_w & w_cnt_at_len;
  assign wd_ready     = w_in_w & m_axi.WREADY;

  assign m_axi.RREADY = w_in_r & rd_ready;
  assign rd_valid     = w_in_r & m_axi.RVALID;
  assign rd_last      = w_in_r & m_axi.RLAST;
  assign rd_data      = m_axi.RDATA;

  assign m_axi.AWADDR  = r_addr;
  assign m_axi.AWLEN   = r_len;
  assign m_axi.AWSIZE  = BEAT_SIZE;
  assign m_axi.AWVALID = r_awvalid;
  assign m_axi.ARADDR  = r_addr;
  assign m_axi.ARLEN   = r_len;
  assign m_axi.ARSIZE  = BEAT_SIZE;
  assign m_axi.ARVALID = r_arvalid;
  assign m_axi.BREADY  = r_bready;

  assign cmd_ready = r_cmd_ready;
  assign done      = r_done;
  assign done_resp = r_done_resp;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= ST_IDLE;
      r_cmd_ready <= 1'b1;
      r_awvalid   <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_done      <= 1'b0;
      r_done_resp <= RESP_OKAY;
      r_resp_acc  <= RESP_OKAY;
      r_addr      <= '0;
      r_len       <= '0;
      r_cnt       <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          // cmd_ready is held low for the cycle that carries the done pulse.
          if (r_cmd_ready && cmd_valid) begin
            r_cmd_ready <= 1'b0;
            r_addr      <= cmd_addr;
            r_len       <= cmd_len;
            r_cnt       <= '0;
            r_resp_acc  <= RESP_OKAY;
            if (cmd_write) begin
              r_awvalid <= 1'b1;
              r_state   <= ST_AW_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_AR_REQ;
            end
          end else begin
            r_cmd_ready <= 1'b1;
          end
        end
        ST_AW_REQ: begin
          if (m_axi.AWREADY) begin
            r_awvalid <= 1'b0;
            r_state   <= ST_W_DATA;
          end
        end
        ST_W_DATA: begin
          if (w_w_hs) begin
            if (w_cnt_at_len) begin
              r_bready <= 1'b1;
              r_state  <= ST_B_WAIT;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        ST_B_WAIT: begin
          if (m_axi.BVALID) begin
            r_bready    <= 1'b0;
            r_done      <= 1'b1;
            r_done_resp <= m_axi.BRESP;
            r_state     <= ST_IDLE;
          end
        end
        ST_AR_REQ: begin
          if (m_axi.ARREADY) begin
            r_arvalid <= 1'b0;
            r_state   <= ST_R_DATA;
          end
        end
        ST_R_DATA: begin
          if (w_r_hs) begin
            r_resp_acc <= w_resp_next;
            if (m_axi.RLAST || w_cnt_at_len) begin
              r_done      <= 1'b1;
              r_done_resp <= (m_axi.RLAST && !w_cnt_at_len) ? RESP_SLVERR : w_resp_next;
              r_state     <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Bench for axi4_burst_master: a memory slave on the bus, a command-level
// reference memory, and one task per scenario.
`timescale 1ns/1ps
module tb_axi4_burst_master;
  import axi4_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam logic [17:0] RST_VEC = {1'b1, 9'b0, 2'b00, 3'd2, 3'd2};

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [DW-1:0] wd_data, rd_data;
  logic          wd_valid, wd_ready, rd_valid, rd_last, rd_ready, done;
  logic [1:0]    done_resp;

  axi4_burst_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  axi4_burst_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_data(wd_data), .wd_valid(wd_valid), .wd_ready(wd_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .done(done), .done_resp(done_resp),
    .m_axi(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] ref_mem [0:16383];
  logic [DW-1:0] wbeats[$];

  // Slave knobs
  int aw_stall = 0;
  bit w_rand = 1'b1;
  bit r_gaps = 1'b1;
  int r_early = -1;
  int r_err_beat = -1;

  // Slave state
  logic [DW-1:0] s_mem [0:16383];
  logic [DW-1:0] s_wq[$];
  logic [AW-1:0] s_awaddr, s_araddr;
  int  aw_wait, s_awlen, s_arlen, s_wbeat, s_rbeat;
  bit  s_werr, s_rerr, b_pend, s_r_active;

  // A burst that runs past a 4KB boundary is rejected by the slave with SLVERR.
  function automatic bit crosses(input logic [AW-1:0] a, input int len);
    return (int'(a[11:0]) + (len + 1) * 4) > 4096;
  endfunction

  function automatic logic [17:0] reset_vec();
    return {cmd_ready, bus.AWVALID, bus.ARVALID, bus.WVALID, bus.WLAST, bus.BREADY,
            bus.RREADY, done, wd_ready, rd_valid, done_resp, bus.AWSIZE, bus.ARSIZE};
  endfunction

  function automatic logic [79:0] addr_vec();
    return {bus.AWADDR, bus.AWLEN, bus.ARADDR, bus.ARLEN, bus.WDATA};
  endfunction

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      bus.AWREADY <= 1'b0; bus.WREADY <= 1'b0; bus.BVALID <= 1'b0; bus.BRESP <= 2'b00;
      bus.ARREADY <= 1'b0; bus.RVALID <= 1'b0; bus.RLAST <= 1'b0; bus.RRESP <= 2'b00;
      bus.RDATA <= '0;
      aw_wait <= 0; s_wbeat <= 0; s_werr <= 1'b0; b_pend <= 1'b0;
      s_r_active <= 1'b0; s_rbeat <= 0;
    end else begin
      if (bus.AWVALID && bus.AWREADY) begin
        bus.AWREADY <= 1'b0; aw_wait <= 0;
        s_awaddr <= bus.AWADDR; s_awlen <= int'(bus.AWLEN); s_wbeat <= 0;
        s_werr <= crosses(bus.AWADDR, int'(bus.AWLEN));
      end else if (bus.AWVALID) begin
        if (aw_wait >= aw_stall) bus.AWREADY <= 1'b1;
        else aw_wait <= aw_wait + 1;
      end
      bus.WREADY <= w_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.WVALID && bus.WREADY) begin
        s_wq.push_back(bus.WDATA);
        s_mem[(int'(s_awaddr >> 2) + s_wbeat) & 16'h3FFF] <= bus.WDATA;
        if (s_wbeat == s_awlen) b_pend <= 1'b1;
        s_wbeat <= s_wbeat + 1;
      end
      if (b_pend && !bus.BVALID) begin
        bus.BVALID <= 1'b1; bus.BRESP <= s_werr ? 2'b10 : 2'b00; b_pend <= 1'b0;
      end else if (bus.BVALID && bus.BREADY) begin
        bus.BVALID <= 1'b0;
      end
      if (bus.ARVALID && bus.ARREADY) begin
        bus.ARREADY <= 1'b0; s_araddr <= bus.ARADDR; s_arlen <= int'(bus.ARLEN);
        s_rbeat <= 0; s_rerr <= crosses(bus.ARADDR, int'(bus.ARLEN)); s_r_active <= 1'b1;
      end else if (bus.ARVALID) begin
        bus.ARREADY <= 1'($urandom_range(0, 1));
      end
      if (s_r_active && (!bus.RVALID || bus.RREADY)) begin
        if (bus.RVALID && bus.RLAST) begin
          bus.RVALID <= 1'b0; bus.RLAST <= 1'b0; s_r_active <= 1'b0;
        end else if (r_gaps && $urandom_range(0, 2) == 0) begin
          bus.RVALID <= 1'b0;
        end else begin
          bus.RVALID <= 1'b1;
          bus.RDATA  <= s_mem[(int'(s_araddr >> 2) + s_rbeat) & 16'h3FFF];
          bus.RLAST  <= (s_rbeat == s_arlen) || (s_rbeat == r_early);
          bus.RRESP  <= (s_rerr || s_rbeat == r_err_beat) ? 2'b10 : 2'b00;
          s_rbeat    <= s_rbeat + 1;
        end
      end
    end
  end

  task automatic run_write(input logic [AW-1:0] addr, input int len, input int stall,
                           input int abort_at, output int wait_cyc);
    int beat;
    bit fin, aborted, aw_seen, aw_done, aw_moved, early_w, bad_q;
    logic [1:0] exp_resp, resp;
    exp_resp = crosses(addr, len) ? 2'b10 : 2'b00;
    s_wq.delete(); aw_stall = stall;
    beat = 0; fin = 0; aborted = 0; aw_seen = 0; aw_done = 0; aw_moved = 0; early_w = 0;
    resp = 2'b00;
    @(negedge ACLK); cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = addr; cmd_len = 8'(len); #1;
    wait_cyc = 0;
    while (!cmd_ready && wait_cyc < 50) begin @(negedge ACLK); #1; wait_cyc++; end
    @(negedge ACLK); cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (cyc != 0) @(negedge ACLK);
      wd_valid = (beat <= len) && ($urandom_range(0, 3) != 0);
      wd_data  = (beat <= len) ? wbeats[beat] : '0;
      #1;
      if (bus.AWVALID) begin
        aw_seen = 1'b1;
        if (bus.AWADDR !== addr || bus.AWLEN !== 8'(len)) aw_moved = 1'b1;
      end
      if (!aw_done && (wd_ready || bus.WVALID)) early_w = 1'b1;
      if (bus.AWVALID && bus.AWREADY) aw_done = 1'b1;
      if (wd_valid && wd_ready) begin
        n_cmp++;
        if (bus.WLAST !== (beat == len) || bus.WDATA !== wd_data) begin
          n_err++;
          $display("FAIL w_beat%0d @%0h: WLAST=%b WDATA=%h, required WLAST=%b WDATA=%h",
                   beat, addr, bus.WLAST, bus.WDATA, (beat == len), wd_data);
        end
        beat++;
        if (beat == abort_at) begin
          @(negedge ACLK); wd_valid = 1'b0; ARESETn = 1'b0; #1;
          n_cmp++;
          if (reset_vec() !== RST_VEC) begin
            n_err++; $display("FAIL mid_reset_ctrl: got %b, required %b", reset_vec(), RST_VEC);
          end
          n_cmp++;
          if (addr_vec() !== '0) begin
            n_err++; $display("FAIL mid_reset_bus: got %h, required 0", addr_vec());
          end
          aborted = 1'b1; fin = 1'b1;
        end
      end
      if (!fin && done) begin
        resp = done_resp; fin = 1'b1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
          n_err++; $display("FAIL w_ready_at_done: cmd_ready=%b, required 0", cmd_ready);
        end
      end
    end
    wd_valid = 1'b0;
    n_cmp++;
    if (!fin) begin
      n_err++; $display("FAIL w_timeout @%0h: done=0 after cycle budget, required done=1", addr);
    end else if (!aborted) begin
      n_cmp++;
      if (beat != len + 1) begin
        n_err++; $display("FAIL w_beats @%0h: got %0d, required %0d", addr, beat, len + 1);
      end
      n_cmp++;
      if (early_w || !aw_seen || aw_moved) begin
        n_err++;
        $display("FAIL aw_order @%0h: early_w=%b aw_seen=%b aw_moved=%b, required 0 1 0",
                 addr, early_w, aw_seen, aw_moved);
      end
      bad_q = (s_wq.size() != len + 1);
      for (int i = 0; i <= len && !bad_q; i++) if (s_wq[i] !== wbeats[i]) bad_q = 1'b1;
      n_cmp++;
      if (bad_q) begin
        n_err++; $display("FAIL slave_wdata @%0h: %0d beats received, required %0d matching beats",
                          addr, s_wq.size(), len + 1);
      end
      n_cmp++;
      if (resp !== exp_resp) begin
        n_err++; $display("FAIL b_resp @%0h: got %b, required %b", addr, resp, exp_resp);
      end
      for (int i = 0; i <= len; i++) ref_mem[(int'(addr >> 2) + i) & 16'h3FFF] = wbeats[i];
    end
  endtask

  // rmode: 0 always ready, 1 ready one cycle in three, 2 random
  task automatic run_read(input logic [AW-1:0] addr, input int len, input int rmode,
                          input int early, input int errb, output int wait_cyc);
    int beat, nbeats;
    bit fin, rr_bad, ar_moved;
    logic [1:0] exp_resp, resp;
    logic [DW-1:0] exp_d;
    nbeats = (early >= 0 && early < len) ? early + 1 : len + 1;
    exp_resp = (crosses(addr, len) || (early >= 0 && early < len) || (errb >= 0 && errb < nbeats))
               ? 2'b10 : 2'b00;
    r_early = early; r_err_beat = errb;
    beat = 0; fin = 0; rr_bad = 0; ar_moved = 0; resp = 2'b00;
    @(negedge ACLK); cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = addr; cmd_len = 8'(len); #1;
    wait_cyc = 0;
    while (!cmd_ready && wait_cyc < 50) begin @(negedge ACLK); #1; wait_cyc++; end
    @(negedge ACLK); cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (cyc != 0) @(negedge ACLK);
      rd_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      #1;
      if (bus.ARVALID && (bus.ARADDR !== addr || bus.ARLEN !== 8'(len))) ar_moved = 1'b1;
      if ((bus.RREADY && !rd_ready) || (rd_valid && bus.RREADY !== rd_ready)) rr_bad = 1'b1;
      if (rd_valid && rd_ready) begin
        exp_d = ref_mem[(int'(addr >> 2) + beat) & 16'h3FFF];
        n_cmp++;
        if (rd_data !== exp_d || rd_last !== (beat == nbeats - 1)) begin
          n_err++;
          $display("FAIL r_beat%0d @%0h: rd_data=%h rd_last=%b, required %h %b",
                   beat, addr, rd_data, rd_last, exp_d, (beat == nbeats - 1));
        end
        beat++;
      end
      if (done) begin
        resp = done_resp; fin = 1'b1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
          n_err++; $display("FAIL r_ready_at_done: cmd_ready=%b, required 0", cmd_ready);
        end
      end
    end
    rd_ready = 1'b0; r_early = -1; r_err_beat = -1;
    n_cmp++;
    if (!fin) begin
      n_err++; $display("FAIL r_timeout @%0h: done=0 after cycle budget, required done=1", addr);
    end else begin
      n_cmp++;
      if (beat != nbeats || rr_bad || ar_moved) begin
        n_err++;
        $display("FAIL r_stream @%0h: beats=%0d rready_bad=%b ar_moved=%b, required %0d 0 0",
                 addr, beat, rr_bad, ar_moved, nbeats);
      end
      n_cmp++;
      if (resp !== exp_resp) begin
        n_err++; $display("FAIL r_resp @%0h: got %b, required %b", addr, resp, exp_resp);
      end
    end
  endtask

  task automatic fill_beats(input int len);
    wbeats.delete();
    for (int i = 0; i <= len; i++) wbeats.push_back($urandom);
  endtask

  task automatic test_reset();
    @(negedge ACLK); #1;
    n_cmp++;
    if (reset_vec() !== RST_VEC) begin
      n_err++; $display("FAIL reset_ctrl: got %b, required %b", reset_vec(), RST_VEC);
    end
    n_cmp++;
    if (addr_vec() !== '0) begin
      n_err++; $display("FAIL reset_bus: got %h, required 0", addr_vec());
    end
    @(negedge ACLK); ARESETn = 1'b1;
    repeat (2) @(negedge ACLK);
    #1;
    n_cmp++;
    if (reset_vec() !== RST_VEC) begin
      n_err++; $display("FAIL idle_after_reset: got %b, required %b", reset_vec(), RST_VEC);
    end
  endtask

  task automatic test_write_basic();
    int wc;
    wbeats.delete();
    for (int i = 0; i < 4; i++) wbeats.push_back(DW'(32'hA0 + i));
    run_write(16'h0010, 3, 0, -1, wc);
  endtask

  task automatic test_read_basic();
    int wc;
    run_read(16'h0010, 3, 0, -1, -1, wc);
  endtask

  task automatic test_write_4k_cross();
    int wc;
    fill_beats(7);
    run_write(16'h0FF0, 7, 0, -1, wc);
    n_cmp++;
    if (done_resp !== RESP_SLVERR) begin
      n_err++; $display("FAIL cross_4k_resp: got %b, required 10", done_resp);
    end
  endtask

  task automatic test_read_len0_throttled();
    int wc;
    fill_beats(0);
    run_write(16'h0120, 0, 1, -1, wc);
    run_read(16'h0120, 0, 1, -1, -1, wc);
  endtask

  task automatic test_aw_stall();
    int wc;
    fill_beats(3);
    run_write(16'h0200, 3, 5, -1, wc);
    run_read(16'h0200, 3, 2, -1, -1, wc);
  endtask

  task automatic test_reset_mid_burst();
    int wc;
    bit saw_done;
    fill_beats(7);
    run_write(16'h0300, 7, 0, 2, wc);
    @(negedge ACLK); ARESETn = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin @(negedge ACLK); #1; if (done) saw_done = 1'b1; end
    n_cmp++;
    if (saw_done) begin
      n_err++; $display("FAIL no_done_after_reset: done pulsed, required no pulse");
    end
    fill_beats(2);
    run_write(16'h0340, 2, 0, -1, wc);
    run_read(16'h0340, 2, 0, -1, -1, wc);
  endtask

  task automatic test_read_errors();
    int wc;
    fill_beats(5);
    run_write(16'h0400, 5, 0, -1, wc);
    run_read(16'h0400, 5, 0, 2, -1, wc);
    run_read(16'h0400, 5, 2, -1, 1, wc);
  endtask

  task automatic test_long_burst();
    int wc;
    fill_beats(255);
    run_write(16'h0800, 255, 2, -1, wc);
    run_read(16'h0800, 255, 2, -1, -1, wc);
  endtask

  task automatic test_back_to_back();
    int wc;
    fill_beats(1);
    run_write(16'h0500, 1, 0, -1, wc);
    run_read(16'h0500, 1, 0, -1, -1, wc);
    n_cmp++;
    if (wc != 0) begin
      n_err++; $display("FAIL b2b_cmd_ready: waited %0d cycles, required 0", wc);
    end
  endtask

  task automatic test_random();
    int wc, len;
    logic [AW-1:0] a;
    for (int n = 0; n < 6; n++) begin
      a   = AW'(16'h2000 + 4 * $urandom_range(0, 1023));
      len = $urandom_range(0, 15);
      fill_beats(len);
      run_write(a, len, $urandom_range(0, 3), -1, wc);
      run_read(a, len, $urandom_range(0, 2), -1, -1, wc);
    end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0;
    test_reset();
    test_write_basic();
    test_read_basic();
    test_write_4k_cross();
    test_read_len0_throttled();
    test_aw_stall();
    test_reset_mid_burst();
    test_read_errors();
    test_long_burst();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
